dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data memory between two requesters.
//   - CPU MEM stage: LW, SW, and CALL/RET stack accesses.
//   - An external loader/debug port.
//   Registers every memory command and sequences the fixed read latency.
//   Stalls the pipeline until the CPU access completes.
//   Sits between the MEM stage (dm_* signals) and the data memory macro.
// PARAMETERS
//   ADDR_W       16  address width, cpu/ext/mem
//   DATA_W       16  data width, cpu/ext/mem
//   MEM_LAT      1   memory read latency: cycles from mem_en to valid mem_rdata (>=1)
//   STARVE_LIMIT 4   consecutive CPU grants with ext_req pending before ext is forced (FAIR_EN only)
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous, active-high reset
//   cpu_re     in   1       MEM-stage read request (level, held while stalled)
//   cpu_we     in   1       MEM-stage write request (level, held while stalled)
//   cpu_addr   in   ADDR_W  MEM-stage address
//   cpu_wdata  in   DATA_W  MEM-stage write data
//   cpu_rdata  out  DATA_W  read data, valid in the completion cycle
//   cpu_stall  out  1       freeze pipeline; low in the completion cycle
//   ext_req    in   1       external request, held until ext_gnt
//   ext_we     in   1       1 = write, 0 = read; qualified by ext_req
//   ext_addr   in   ADDR_W  external address
//   ext_wdata  in   DATA_W  external write data
//   ext_gnt    out  1       1-cycle pulse; request accepted, command on mem_* this cycle
//   ext_rvalid out  1       1-cycle pulse, MEM_LAT cycles after ext_gnt, reads only
//   ext_rdata  out  DATA_W  read data, valid with ext_rvalid
//   mem_en     out  1       registered memory command strobe
//   mem_we     out  1       registered write enable
//   mem_addr   out  ADDR_W  registered address
//   mem_wdata  out  DATA_W  registered write data
//   mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//   States
//   - IDLE: arbitrate.
//   - ISSUE: mem_* driven for exactly 1 cycle.
//   - WAIT: count MEM_LAT-1 further cycles, reads only.
//   - DONE: 1 cycle; completion; requests ignored.
//   Arbitration, in IDLE only
//   - CPU request (cpu_re|cpu_we) beats ext_req.
//   - Winner is registered into mem_* and the FSM moves to ISSUE.
//   - Both cpu_re and cpu_we high: treated as write.
//   CPU write, request seen at cycle N
//   - N+1: ISSUE with mem_en=mem_we=1.
//   - cpu_stall=1 at N and 0 at N+1 (ISSUE doubles as completion).
//   - Next cycle returns to IDLE.
//   CPU read, request seen at cycle N
//   - N+1: ISSUE.
//   - N+1+MEM_LAT: DONE; cpu_rdata=mem_rdata; cpu_stall=0.
//   - Total stall is 1+MEM_LAT cycles.
//   cpu_stall rules
//   - Combinational: (cpu_re|cpu_we) & ~(completion cycle).
//   - Forced 0 while rst=1.
//   - Also 1 while the FSM is busy with an ext access.
//   External access
//   - ext_gnt=1 in the ISSUE cycle.
//   - Reads: ext_rvalid=1 and ext_rdata=mem_rdata MEM_LAT cycles later.
//   - Writes: no rvalid.
//   Completion-cycle rule
//   - Requests present in the DONE/completion cycle are not re-issued.
//   - The pipeline advances on that edge; the next IDLE sees the new instruction.
//   Outputs outside ISSUE
//   - mem_en=0 and mem_we=0.
//   - mem_addr and mem_wdata hold their last values.
//   Reset
//   - State=IDLE; all outputs 0, including cpu_rdata and ext_rdata.
//   - Starve counter=0.
//   - A read in flight at reset is discarded: no ext_rvalid, no DONE.
//   Throughput
//   - Back-to-back accesses are separated by one IDLE cycle.
// CONFIGURATION
//   DMEM_ARB_FAIR_EN defined
//   - Starve counter increments on each CPU grant made while ext_req=1.
//   - Counter clears on any ext grant, or in any IDLE cycle with ext_req=0.
//   - When the counter == STARVE_LIMIT, ext wins the next IDLE arbitration even if the CPU is requesting.
//   DMEM_ARB_FAIR_EN undefined
//   - Strict CPU priority; counter not built.
// TESTING
//   1. MEM_LAT=1; cpu_re, addr=16'h0040, mem holds 16'hBEEF.
//      -> mem_en at N+1; cpu_stall high N,N+1, low N+2 with cpu_rdata=16'hBEEF.
//   2. cpu_we, addr=16'h0010, data=16'h1234.
//      -> mem_en=mem_we=1 and mem_wdata=16'h1234 at N+1; cpu_stall high only at N.
//   3. ext read of 16'h0002 with no CPU request.
//      -> ext_gnt at N+1; ext_rvalid at N+2 with the stored value.
//   4. Same-cycle cpu_re and ext_req.
//      -> CPU served first; ext_gnt one cycle after CPU DONE+IDLE.
//      -> cpu_stall=1 during any later ext-busy cycle.
//   5. rst asserted during WAIT (MEM_LAT=3).
//      -> no ext_rvalid or DONE; all outputs 0 the cycle after rst; next request serviced normally.
//   6. FAIR_EN, STARVE_LIMIT=2; continuous CPU reads with ext_req held.
//      -> ext_gnt after exactly 2 CPU grants.
//      -> Without FAIR_EN, ext_gnt only after cpu requests drop.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU MEM stage vs external loader/debug port, registered memory
// command and fixed-latency read sequencing. Optional ext fairness via DMEM_ARB_FAIR_EN.
module dmem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int             CNT_W     = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
    localparam bit             LAT_ONE   = (MEM_LAT == 1);

    state_t              state_q, state_d;
    logic                own_ext_q, own_ext_d;
    logic                rd_q, rd_d;
    logic [CNT_W-1:0]    lat_q, lat_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   ext_rdata_q, ext_rdata_d;
    logic                cpu_req_s;
    logic                pick_ext_s;

    assign cpu_req_s = cpu_re | cpu_we;

`ifdef DMEM_ARB_FAIR_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q, starve_d;

    assign pick_ext_s = ext_req & (~cpu_req_s | (starve_q == SW'(STARVE_LIMIT)));

    // Starvation counter: counts CPU grants that bypassed a waiting ext request
    always_comb begin
        starve_d = starve_q;
        if (state_q == S_IDLE) begin
            if (pick_ext_s) begin
                starve_d = {SW{1'b0}};
            end else if (cpu_req_s && ext_req) begin
                starve_d = starve_q + SW'(1);
            end else if (!ext_req) begin
                starve_d = {SW{1'b0}};
            end else begin
                starve_d = starve_q;
            end
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= {SW{1'b0}};
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic [31:0] starve_limit_unused_s;
    assign starve_limit_unused_s = 32'(STARVE_LIMIT);
    assign pick_ext_s = ext_req & ~cpu_req_s;
`endif

    // State and registered memory command
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            own_ext_q   <= 1'b0;
            rd_q        <= 1'b0;
            lat_q       <= {CNT_W{1'b0}};
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            cpu_rdata_q <= {DATA_W{1'b0}};
            ext_rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            own_ext_q   <= own_ext_d;
            rd_q        <= rd_d;
            lat_q       <= lat_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ext_rdata_q <= ext_rdata_d;
        end
    end

    // Next state: arbitrate in IDLE, then sequence the access
    always_comb begin
        state_d     = state_q;
        own_ext_d   = own_ext_q;
        rd_d        = rd_q;
        lat_d       = lat_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ext_rdata_d = ext_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (pick_ext_s) begin
                    state_d     = S_ISSUE;
                    own_ext_d   = 1'b1;
                    rd_d        = ~ext_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = ext_we;
                    mem_addr_d  = ext_addr;
                    mem_wdata_d = ext_wdata;
                end else if (cpu_req_s) begin
                    state_d     = S_ISSUE;
                    own_ext_d   = 1'b0;
                    rd_d        = ~cpu_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = cpu_we;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (!rd_q) begin
                    state_d = S_IDLE;
                end else if (LAT_ONE) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                    lat_d   = WAIT_INIT;
                end
            end
            S_WAIT: begin
                if (lat_q == {CNT_W{1'b0}}) begin
                    state_d = S_DONE;
                end else begin
                    lat_d = lat_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (own_ext_q) begin
                    ext_rdata_d = mem_rdata;
                end else begin
                    cpu_rdata_d = mem_rdata;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; read data passes through in the completion cycle
    always_comb begin
        ext_gnt    = (state_q == S_ISSUE) && own_ext_q;
        ext_rvalid = (state_q == S_DONE) && own_ext_q;
        cpu_stall  = 1'b0;
        if (rst) begin
            cpu_stall = 1'b0;
        end else if ((state_q != S_IDLE) && own_ext_q) begin
            cpu_stall = 1'b1;
        end else if (!own_ext_q && (((state_q == S_ISSUE) && !rd_q) || (state_q == S_DONE))) begin
            cpu_stall = 1'b0;
        end else begin
            cpu_stall = cpu_req_s;
        end
        if ((state_q == S_DONE) && !own_ext_q) begin
            cpu_rdata = mem_rdata;
        end else begin
            cpu_rdata = cpu_rdata_q;
        end
        if ((state_q == S_DONE) && own_ext_q) begin
            ext_rdata = mem_rdata;
        end else begin
            ext_rdata = ext_rdata_q;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
